// File: rtl/sub_pkg.sv
// Shared types and default sizing for the bit-serial subtractor.
// Holds the FSM state encoding and the default operand/counter widths.
package sub_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } sub_state_t;

    localparam int SUB_WIDTH = 4;
    localparam int SUB_CNT_W = $clog2(SUB_WIDTH) + 1;

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/done handshake bundle between a requester (master) and the serial subtractor (slave).
// No flow control beyond start/busy/done; the requester must watch busy.
interface serial_subtractor_if
    import sub_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow
    );
endinterface

// File: rtl/serial_subtractor_fs_cell.sv
// One-bit full subtractor, purely combinational, zero latency.
// No state and no backpressure; evaluated once per serial bit.
module fs_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic br_i,
    output logic d_o,
    output logic br_o
);
    assign d_o  = a_i ^ b_i ^ br_i;
    assign br_o = (~a_i & b_i) | (~(a_i ^ b_i) & br_i);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first; done pulses WIDTH+1 cycles after an accepted start, start ignored unless IDLE.
// `define SERIAL_SUB_SATURATE_EN to floor diff at 0 on borrow; latency and handshake are unchanged.
module serial_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_subtractor_if.slave  sub_if
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    sub_state_t       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             br_q, br_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             done_q, done_d;

    logic             bit_d;
    logic             bit_br;

    fs_cell u_fs_cell (
        .a_i  (a_q[0]),
        .b_i  (b_q[0]),
        .br_i (br_q),
        .d_o  (bit_d),
        .br_o (bit_br)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            br_q     <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            br_q     <= br_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        br_d     = br_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        done_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (sub_if.start) begin
                    a_d     = sub_if.a;
                    b_d     = sub_if.b;
                    res_d   = '0;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                // Each difference bit enters at the MSB, so after WIDTH shifts bit 0 holds the LSB.
                res_d = {bit_d, res_q[WIDTH-1:1]};
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                br_d  = bit_br;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
`ifdef SERIAL_SUB_SATURATE_EN
                diff_d = br_q ? '0 : res_q;
`else
                diff_d = res_q;
`endif
                borrow_d = br_q;
                done_d   = 1'b1;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign sub_if.busy   = (state_q == S_SHIFT);
    assign sub_if.done   = done_q;
    assign sub_if.diff   = diff_q;
    assign sub_if.borrow = borrow_q;
endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial, multi-cycle subtractor computing a - b over WIDTH clock cycles, LSB first.
- Companion to the registered 4-bit adder: same operand widths and clocking, start/done handshake.
- Used where subtraction results feed back into adder datapaths, and as an area-cheap arithmetic unit.
- Registered outputs are held stable between operations.

Parameters:
- WIDTH, 4, operand and difference width in bits (>= 2).
- CNT_W, $clog2(WIDTH)+1, local; bit-counter width.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  minuend; captured on accepted start.
- b  input  WIDTH  subtrahend; captured on accepted start.
- busy  output  1  high while an operation is in progress (SHIFT state).
- done  output  1  one-cycle pulse; diff/borrow valid from that cycle.
- diff  output  WIDTH  difference, mod 2^WIDTH (see optional feature).
- borrow  output  1  final borrow; 1 iff a < b (unsigned).

Behaviour:
- Interface: one clock, clk; reset rst_n, synchronous, active-low. Reset takes effect only on a rising clk edge while rst_n = 0.
- Reset values: state IDLE; busy = 0, done = 0, diff = 0, borrow = 0; internal shift registers, borrow flop and counter = 0.
- FSM has three states:
  - IDLE: start = 1 at edge k latches a, b into shift registers, clears the borrow flop and counter, and moves to SHIFT. busy = 1 from edge k.
  - SHIFT: each edge processes bit 0 of the shift registers:
    - d = a0 ^ b0 ^ br.
    - br_next = (~a0 & b0) | (~(a0 ^ b0) & br).
    - d shifts into the result MSB; operands shift right; counter increments.
    - After WIDTH bits (counter = WIDTH-1 processed) the state moves to DONE.
  - DONE: diff and borrow load from the result register and final borrow. done = 1 and busy = 0 for exactly that cycle. Next edge returns to IDLE.
- Latency: start sampled at edge k; done high after edge k+WIDTH+1 (5 cycles for WIDTH = 4). One operation per WIDTH+2 cycles maximum.
- start while busy or in DONE is ignored; there is no queueing.
- start held high continuously re-triggers on each return to IDLE.
- diff and borrow hold their last values until the next DONE. They do not change during SHIFT.
- Operand changes after capture have no effect.
- rst_n low mid-operation aborts the operation. All outputs return to reset values at that edge, and no done pulse is issued.
- Arithmetic is unsigned. a = b gives diff 0, borrow 0. The a = 0, b = 2^WIDTH-1 boundary gives diff 1, borrow 1.

Optional Feature:
- Macro: SERIAL_SUB_SATURATE_EN.
- Defined: when the final borrow = 1, diff loads 0 (saturating floor). borrow still reports 1.
- Undefined: diff is the wrapped two's-complement result mod 2^WIDTH.
- Latency and handshake are identical in both builds.

Decomposition:
- Shared package sub_pkg holds:
  - state enum type sub_state_t {S_IDLE, S_SHIFT, S_DONE}.
  - default width constant SUB_WIDTH = 4.
  - its counter width.
- Sub-module fs_cell: combinational one-bit full subtractor.
  - Inputs a_i, b_i, br_i; outputs d_o, br_o.
  - Instantiated once in the serial datapath.
- The top level holds the FSM, shift registers, counter and output registers.

Test Plan:
- Reset then a=7, b=3, start pulse: busy high for 4 cycles; done pulse 5 cycles after start; diff=4, borrow=0.
- a=3, b=4: diff=15, borrow=1. With SERIAL_SUB_SATURATE_EN: diff=0, borrow=1.
- a=15, b=15 then a=0, b=15 back-to-back:
  - first result diff=0, borrow=0.
  - second result diff=1, borrow=1 (saturated build: diff=0).
  - second start accepted only after return to IDLE.
- a=9, b=2 started; start re-pulsed with a=1, b=1 two cycles later: second start ignored; result diff=7, borrow=0; outputs stable until the next accepted start.
- a=8, b=7 started; rst_n low at third SHIFT cycle: next edge gives busy=0, done=0, diff=0, borrow=0; no done pulse follows; a fresh start completes normally.
- Randomised check, 200 operand pairs against a reference model a - b, checking diff, borrow and exact done timing.
